// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad emulator:
//   - key_state_t : 3-bit press-playback FSM encoding
//   - KEY_COL/KEY_ROW field positions inside the 4-bit key code
//   - chatter LFSR taps and its next-state helper
// Configuration macro consumed by users of this package: KEYPAD_EMU_BOUNCE_EN
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } key_state_t;

  localparam int unsigned KEY_CODE_W  = 4;
  localparam int unsigned KEY_COL_MSB = 3;
  localparam int unsigned KEY_COL_LSB = 2;
  localparam int unsigned KEY_ROW_MSB = 1;
  localparam int unsigned KEY_ROW_LSB = 0;

  // Fibonacci taps 8,6,5,4 (bit 8 is the MSB, bit 7 of the register)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [1:0] key_col(input logic [KEY_CODE_W-1:0] code);
    return code[KEY_COL_MSB:KEY_COL_LSB];
  endfunction

  function automatic logic [1:0] key_row(input logic [KEY_CODE_W-1:0] code);
    return code[KEY_ROW_MSB:KEY_ROW_LSB];
  endfunction

  // Shift toward the MSB, feedback parity enters at bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo
//   Synchronous FIFO holding queued press requests {key_code, key_hold}.
//   Storage is registered; dout shows the head entry with no read-through,
//   so a word pushed into an empty FIFO becomes visible the next cycle.
// Ports
//   clk      in  1      system clock
//   reset_n  in  1      asynchronous active-low reset
//   flush    in  1      synchronous clear, wins over push and pop
//   push     in  1      write din (ignored when full)
//   pop      in  1      drop head entry (ignored when empty)
//   din      in  WIDTH  entry to write
//   dout     out WIDTH  head entry
//   full     out 1      DEPTH entries stored
//   empty    out 1      no entries stored
module key_event_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Responder side of a 4x4 matrix keypad. Queued press requests are played
//   back one at a time as timed contact closures on the row lines, driven
//   from the scanner's column drive with zero latency.
//   Optional contact chatter is enabled by defining KEYPAD_EMU_BOUNCE_EN;
//   without it each bounce phase is a single clean cycle and no LFSR exists.
// Ports
//   clk        in  1       system clock
//   reset_n    in  1       asynchronous active-low reset
//   column     in  4       scanner column drive, active-high
//   row        out 4       emulated row return, active-high
//   key_valid  in  1       press request valid
//   key_code   in  4       [3:2] column index, [1:0] row index
//   key_hold   in  HOLD_W  closed time in cycles (0 behaves as 1)
//   key_ready  out 1       request accepted on key_valid & key_ready
//   flush      in  1       drop queue and release current key
//   busy       out 1       press in progress or queue not empty
//   contact    out 1       current contact state (1 = closed)
//   key_done   out 1       pulse on the last GAP cycle of a press
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_W        = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned GAP_CYCLES    = 32,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            column,
  output logic [3:0]            row,
  input  logic                  key_valid,
  input  logic [KEY_CODE_W-1:0] key_code,
  input  logic [HOLD_W-1:0]     key_hold,
  output logic                  key_ready,
  input  logic                  flush,
  output logic                  busy,
  output logic                  contact,
  output logic                  key_done
);

  localparam int unsigned ENTRY_W = KEY_CODE_W + HOLD_W;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int unsigned BOUNCE_LEN = BOUNCE_CYCLES;
`else
  // Clean build: bounce phases are one cycle and the chatter settings have no effect
  localparam int unsigned BOUNCE_LEN = ((BOUNCE_CYCLES > 0) && (LFSR_SEED != 8'd0)) ? 1 : 1;
`endif

  localparam logic [HOLD_W-1:0] BOUNCE_LAST = HOLD_W'(BOUNCE_LEN - 1);
  localparam logic [HOLD_W-1:0] GAP_LAST    = HOLD_W'(GAP_CYCLES - 1);

  key_state_t                state;
  key_state_t                next_state;
  logic [HOLD_W-1:0]         cnt;
  logic [HOLD_W-1:0]         cnt_next;
  logic [KEY_CODE_W-1:0]     cur_code;
  logic [HOLD_W-1:0]         cur_hold;
  logic [HOLD_W-1:0]         hold_last;
  logic [ENTRY_W-1:0]        fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      bounce_last;
  logic                      chatter;

  assign fifo_push = key_valid & ~fifo_full & ~flush;
  assign key_ready = ~fifo_full;

  key_event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     ({key_code, key_hold}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A zero hold still closes the contact for one cycle
  assign hold_last   = (cur_hold == '0) ? '0 : (cur_hold - HOLD_W'(1));
  assign bounce_last = (cnt == BOUNCE_LAST);

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [7:0] lfsr;
  logic       in_bounce;

  assign in_bounce = (state == ST_BOUNCE_IN) || (state == ST_BOUNCE_OUT);
  assign chatter   = lfsr[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (in_bounce) begin
      lfsr <= lfsr_next(lfsr);
    end
  end
`else
  // Never sampled: every clean bounce cycle is also its last cycle
  assign chatter = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur_code <= '0;
      cur_hold <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (fifo_pop) begin
        cur_code <= fifo_dout[HOLD_W +: KEY_CODE_W];
        cur_hold <= fifo_dout[HOLD_W-1:0];
      end
    end
  end

  // The last cycle of each bounce phase forces the settled contact level
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    fifo_pop   = 1'b0;
    contact    = 1'b0;
    key_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = ST_BOUNCE_IN;
          cnt_next   = '0;
        end
      end
      ST_BOUNCE_IN: begin
        contact = bounce_last ? 1'b1 : chatter;
        if (bounce_last) begin
          next_state = ST_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + HOLD_W'(1);
        end
      end
      ST_HOLD: begin
        contact = 1'b1;
        if (cnt == hold_last) begin
          next_state = ST_BOUNCE_OUT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + HOLD_W'(1);
        end
      end
      ST_BOUNCE_OUT: begin
        contact = bounce_last ? 1'b0 : chatter;
        if (bounce_last) begin
          next_state = ST_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          key_done   = 1'b1;
          next_state = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + HOLD_W'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (flush) begin
      next_state = ST_IDLE;
      cnt_next   = '0;
      fifo_pop   = 1'b0;
    end
  end

  assign busy = (state != ST_IDLE) || !fifo_empty;

  // Only the current key's column bit matters, even with several columns active
  always_comb begin
    row = 4'b0000;
    if (contact && column[key_col(cur_code)]) begin
      row[key_row(cur_code)] = 1'b1;
    end
  end

endmodule
